// File: rtl/rob_resp_serializer.sv
// rob_resp_serializer
// Takes one in-order cache-line response per valid/ready handshake from the
// reorder buffer and replays it on the host read-data channel as BEATS beats,
// low beat first, with rlast_o on the final beat. A new line can be accepted
// on the last-beat handshake, so back-to-back lines stream with no bubble.
module rob_resp_serializer #(
   parameter int LINE_W = 512,
   parameter int BEAT_W = 128,
   parameter int ID_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [ID_W-1:0]   rid_i,
   input  logic [LINE_W-1:0] rdata_i,
   output logic              rvalid_o,
   input  logic              rready_i,
   output logic [ID_W-1:0]   rid_o,
   output logic [BEAT_W-1:0] rdata_o,
   output logic              rlast_o,
   output logic              busy_o
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  beat_cnt;
   // Beats of the current line not yet loaded into rdata_o, next beat in the
   // low BEAT_W bits; shifting avoids a wide variable-index mux.
   logic [LINE_W-1:0] line_q;

   logic beat_hs;
   logic accept;

   assign beat_hs = rvalid_o & rready_i;

   // NOTE: ready_o is a continuous assign, not a register. It must see the
   // last-beat handshake in the same cycle so the next line is taken without
   // a bubble; this rready_i -> ready_o path is the only combinational one.
   assign ready_o = !rst & ((state == IDLE) | (rvalid_o & rlast_o & rready_i));
   assign accept  = valid_i & ready_o;
   assign busy_o  = (state == SEND);

   // Line capture, beat sequencing and registered host-channel outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples pre-edge values regardless of statement order.
      if (rst) begin
         // The line register is reset too, so a discarded line never leaks
         // into a later beat.
         state    <= IDLE;
         beat_cnt <= '0;
         line_q   <= '0;
         rid_o    <= '0;
         rdata_o  <= '0;
         rvalid_o <= 1'b0;
         rlast_o  <= 1'b0;
      end else if (accept) begin
         // Also covers acceptance on the last-beat handshake of the previous line.
         state    <= SEND;
         beat_cnt <= '0;
         line_q   <= rdata_i >> BEAT_W;
         rid_o    <= rid_i;
         rdata_o  <= rdata_i[BEAT_W-1:0];
         rvalid_o <= 1'b1;
         rlast_o  <= (LAST_CNT == '0);
      end else if (beat_hs) begin
         if (rlast_o) begin
            state    <= IDLE;
            rvalid_o <= 1'b0;
            rlast_o  <= 1'b0;
         end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            rdata_o  <= line_q[BEAT_W-1:0];
            line_q   <= line_q >> BEAT_W;
            rlast_o  <= ((beat_cnt + CNT_W'(1)) == LAST_CNT);
         end
      end
   end

endmodule

// File: tb/tb_rob_resp_serializer.sv
// Testbench for rob_resp_serializer: directed scenarios followed by 1000
// randomised lines. A monitor watches the ROB-side handshake, expands each
// accepted line into its expected beats in a queue, and compares every
// host-side beat and the valid/ready/busy flags against that queue.
module tb_rob_resp_serializer;

   localparam int LINE_W = 512;
   localparam int BEAT_W = 128;
   localparam int ID_W   = 16;
   localparam int BEATS  = LINE_W / BEAT_W;
   localparam int N_RAND = 1000;
   localparam int N_DIR  = 8;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [BEAT_W-1:0] data;
      logic              last;
   } beat_t;

   logic              clk;
   logic              rst;
   logic              valid_i;
   logic              ready_o;
   logic [ID_W-1:0]   rid_i;
   logic [LINE_W-1:0] rdata_i;
   logic              rvalid_o;
   logic              rready_i;
   logic [ID_W-1:0]   rid_o;
   logic [BEAT_W-1:0] rdata_o;
   logic              rlast_o;
   logic              busy_o;

   rob_resp_serializer #(
      .LINE_W(LINE_W),
      .BEAT_W(BEAT_W),
      .ID_W  (ID_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .rid_i   (rid_i),
      .rdata_i (rdata_i),
      .rvalid_o(rvalid_o),
      .rready_i(rready_i),
      .rid_o   (rid_o),
      .rdata_o (rdata_o),
      .rlast_o (rlast_o),
      .busy_o  (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_cmp  = 0;
   int    n_fail = 0;
   int    lines_acc = 0;
   beat_t exp_q[$];

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, halfway between driving (just
   // after posedge) and the DUT's active edge.
   logic              rst_prev   = 1'b0;
   logic              prev_stall = 1'b0;
   logic [ID_W-1:0]   prev_rid;
   logic [BEAT_W-1:0] prev_rdata;
   logic              prev_rlast;

   always @(negedge clk) begin
      if (rst) begin
         check("ready_in_reset", ready_o, 1'b0);
         if (rst_prev) begin
            check("rvalid_in_reset", rvalid_o, 1'b0);
            check("busy_in_reset", busy_o, 1'b0);
            check("rlast_in_reset", rlast_o, 1'b0);
            check("rid_in_reset", rid_o, '0);
            check("rdata_in_reset", rdata_o, '0);
         end
         exp_q.delete();
         prev_stall = 1'b0;
         rst_prev   = 1'b1;
      end else begin
         logic exp_ready;
         rst_prev = 1'b0;
         // A line is pending while any of its beats are outstanding; the host
         // channel must present beats exactly then, and the ROB side is free
         // when nothing is pending or the final pending beat is being taken.
         exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && rready_i);
         check("rvalid", rvalid_o, exp_q.size() != 0);
         check("busy", busy_o, exp_q.size() != 0);
         check("ready", ready_o, exp_ready);
         if (prev_stall) begin
            check("stall_rid", rid_o, prev_rid);
            check("stall_rdata", rdata_o, prev_rdata);
            check("stall_rlast", rlast_o, prev_rlast);
         end
         if (rvalid_o && rready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", rvalid_o, 1'b0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("beat_rid", rid_o, b.id);
               check("beat_rdata", rdata_o, b.data);
               check("beat_rlast", rlast_o, b.last);
            end
         end
         if (valid_i && ready_o) begin
            lines_acc++;
            for (int k = 0; k < BEATS; k++) begin
               beat_t b;
               b.id   = rid_i;
               b.data = rdata_i[k*BEAT_W +: BEAT_W];
               b.last = (k == BEATS - 1);
               exp_q.push_back(b);
            end
         end
         prev_stall = rvalid_o && !rready_i;
         prev_rid   = rid_o;
         prev_rdata = rdata_o;
         prev_rlast = rlast_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] d;
      for (int k = 0; k < LINE_W / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   // Offer one line, hold it until accepted, then scramble the inputs and
   // idle for gap cycles. Returns 1 cycle-phase after the accepting edge.
   task automatic send_line(input logic [ID_W-1:0] id, input logic [LINE_W-1:0] d,
                            input int gap);
      int n = 0;
      valid_i = 1'b1;
      rid_i   = id;
      rdata_i = d;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_o && n < 300);
      if (!ready_o) check("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      rid_i   = ID_W'($urandom);
      rdata_i = rand_line();
      repeat (gap) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   bit done = 1'b0;

   initial begin
      int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      rst      = 1'b1;
      valid_i  = 1'b0;
      rready_i = 1'b0;
      rid_i    = '0;
      rdata_i  = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // 1: single line, host always ready
      rready_i = 1'b1;
      send_line(16'h0002, 512'hbb, 6);

      // 2: back-to-back lines, zero bubble
      send_line(16'h0003, 512'hcc, 0);
      send_line(16'h0004, 512'hdd, 10);

      // 3: backpressure pattern on the host side
      rready_i = 1'b0;
      send_line(16'h0008, {128'h4, 128'h3, 128'h2, 128'h1}, 0);
      for (int i = 0; i < 7; i++) begin
         rready_i = pat[i][0];
         step();
      end
      rready_i = 1'b1;
      repeat (3) step();

      // 4: reset after the second beat has been taken
      send_line(16'h0009, rand_line(), 0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      send_line(16'h0005, rand_line(), 6);

      // 5: offer while busy, accepted only on the last-beat handshake
      send_line(16'h0006, rand_line(), 0);
      send_line(16'h0007, rand_line(), 8);

      // 6: randomised traffic on both sides
      fork
         begin
            for (int i = 0; i < N_RAND; i++)
               send_line(ID_W'($urandom), rand_line(), $urandom_range(0, 2));
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               rready_i = ($urandom_range(0, 9) < 7);
            end
         end
      join
      rready_i = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
      repeat (2) step();
      check("drained", exp_q.size(), 0);
      check("lines_accepted", lines_acc, N_DIR + N_RAND);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
